// File: rtl/operand_fetch_if.sv
// Operand fetch bus: request, register-file read port, operand handshake.
// Ports: start/rn_a/rn_b, readnum/data_out, A/B/valid/ready, busy.
interface operand_fetch_if #(
   parameter int n = 16,
   parameter int k = 3
);
   logic         start;
   logic [k-1:0] rn_a;
   logic [k-1:0] rn_b;
   logic [k-1:0] readnum;
   logic [n-1:0] data_out;
   logic [n-1:0] A;
   logic [n-1:0] B;
   logic         valid;
   logic         ready;
   logic         busy;

   modport master (
      output start, rn_a, rn_b, data_out, ready,
      input  readnum, A, B, valid, busy
   );

   modport slave (
      input  start, rn_a, rn_b, data_out, ready,
      output readnum, A, B, valid, busy
   );
endinterface

// File: rtl/operand_fetch.sv
// Reads two source registers through one combinational read port into A/B.
// Ports: clk, reset (sync, active-high), bus (operand_fetch_if.slave).
module operand_fetch #(
   parameter int n = 16,
   parameter int k = 3
) (
   input logic               clk,
   input logic               reset,
   operand_fetch_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ_A = 2'd1,
      READ_B = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t       state;
   logic [k-1:0] ra_q;
   logic [k-1:0] rb_q;
   logic [n-1:0] a_q;
   logic [n-1:0] b_q;
   logic [k-1:0] readnum_q;
   logic         valid_q;
   logic         busy_q;

   // readnum/valid/busy are registered alongside state so they carry
   // no combinational path from start or ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ra_q      <= '0;
         rb_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         readnum_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  ra_q      <= bus.rn_a;
                  rb_q      <= bus.rn_b;
                  readnum_q <= bus.rn_a;
                  busy_q    <= 1'b1;
                  state     <= READ_A;
               end
            end
            READ_A: begin
               a_q <= bus.data_out;
               if (ra_q == rb_q) begin
                  // Same register: one read fills both operands.
                  b_q       <= bus.data_out;
                  readnum_q <= '0;
                  busy_q    <= 1'b0;
                  valid_q   <= 1'b1;
                  state     <= HOLD;
               end else begin
                  readnum_q <= rb_q;
                  state     <= READ_B;
               end
            end
            READ_B: begin
               b_q       <= bus.data_out;
               readnum_q <= '0;
               busy_q    <= 1'b0;
               valid_q   <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (bus.ready) begin
                  valid_q <= 1'b0;
                  if (bus.start) begin
                     ra_q      <= bus.rn_a;
                     rb_q      <= bus.rn_b;
                     readnum_q <= bus.rn_a;
                     busy_q    <= 1'b1;
                     state     <= READ_A;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.readnum = readnum_q;
   assign bus.A       = a_q;
   assign bus.B       = b_q;
   assign bus.valid   = valid_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural 8x16 register file.
// Stimulus pushes expected A/B; a negedge monitor pops on each handshake.
module tb_operand_fetch;

   logic clk;
   logic reset;

   operand_fetch_if #(.n(16), .k(3)) bus ();

   operand_fetch #(.n(16), .k(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rf [8];
   logic        we;
   logic [2:0]  wn;
   logic [15:0] wd;

   assign bus.data_out = rf[bus.readnum];

   always @(posedge clk)
      if (we) rf[wn] <= wd;

   int checks   = 0;
   int failures = 0;
   logic [31:0] expq [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.valid === 1'b1 && bus.ready === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got A=%h B=%h expected none",
                     bus.A, bus.B);
         end else begin
            logic [31:0] e;
            e = expq.pop_front();
            chk("scoreboard_AB", {bus.A, bus.B}, e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic req(input logic [2:0] a, input logic [2:0] b);
      bus.start = 1'b1;
      bus.rn_a  = a;
      bus.rn_b  = b;
      expq.push_back({rf[a], rf[b]});
   endtask

   initial begin
      rf[0] = 16'hC0DE; rf[1] = 16'h0F0F;
      rf[2] = 16'h1234; rf[3] = 16'h3333;
      rf[4] = 16'h00AA; rf[5] = 16'hABCD;
      rf[6] = 16'h5A5A; rf[7] = 16'hFFFF;
      we = 1'b0; wn = '0; wd = '0;
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.rn_a  = 3'd2;
      bus.rn_b  = 3'd5;
      bus.ready = 1'b1;

      // reset with start held high: no fetch may begin
      step();
      step();
      reset = 1'b0; bus.start = 1'b0;
      neg();
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_readnum", {29'd0, bus.readnum}, 32'd0);
      chk("rst_AB", {bus.A, bus.B}, 32'd0);
      step();
      neg();
      chk("rst_nofetch", {31'd0, bus.busy}, 32'd0);

      // distinct fetch R2, R5
      step(); req(3'd2, 3'd5);
      step(); bus.start = 1'b0;
      neg();
      chk("dist_rn_a", {29'd0, bus.readnum}, 32'd2);
      chk("dist_busy_a", {31'd0, bus.busy}, 32'd1);
      chk("dist_nvalid", {31'd0, bus.valid}, 32'd0);
      step(); neg();
      chk("dist_rn_b", {29'd0, bus.readnum}, 32'd5);
      step(); neg();
      chk("dist_valid", {31'd0, bus.valid}, 32'd1);
      chk("dist_busy_h", {31'd0, bus.busy}, 32'd0);
      chk("dist_rn_h", {29'd0, bus.readnum}, 32'd0);
      step(); neg();
      chk("dist_idle", {31'd0, bus.valid}, 32'd0);

      // same-register shortcut R7
      step(); req(3'd7, 3'd7);
      step(); bus.start = 1'b0;
      neg();
      chk("same_rn", {29'd0, bus.readnum}, 32'd7);
      step(); neg();
      chk("same_valid", {31'd0, bus.valid}, 32'd1);
      chk("same_rn0", {29'd0, bus.readnum}, 32'd0);
      step(); neg();
      chk("same_idle", {31'd0, bus.valid}, 32'd0);

      // backpressure with an ignored start pulse
      step(); req(3'd5, 3'd2); bus.ready = 1'b0;
      step(); bus.start = 1'b0;
      step();
      step(); neg();
      chk("bp_valid0", {31'd0, bus.valid}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         bus.start = (i == 1);
         bus.rn_a  = 3'd1;
         bus.rn_b  = 3'd1;
         neg();
         chk("bp_valid", {31'd0, bus.valid}, 32'd1);
         chk("bp_busy", {31'd0, bus.busy}, 32'd0);
         chk("bp_AB", {bus.A, bus.B}, 32'hABCD1234);
      end
      step(); bus.start = 1'b0; bus.ready = 1'b1;
      neg();
      chk("bp_held", {31'd0, bus.valid}, 32'd1);
      step(); neg();
      chk("bp_idle", {31'd0, bus.valid}, 32'd0);
      chk("bp_idle_busy", {31'd0, bus.busy}, 32'd0);

      // back-to-back: R6/R1 then R3/R0 straight from HOLD
      step(); req(3'd6, 3'd1); bus.ready = 1'b0;
      step(); bus.start = 1'b0;
      step();
      step(); neg();
      chk("b2b_valid1", {31'd0, bus.valid}, 32'd1);
      step(); req(3'd3, 3'd0); bus.ready = 1'b1;
      neg();
      step(); bus.start = 1'b0;
      neg();
      chk("b2b_rn_a", {29'd0, bus.readnum}, 32'd3);
      chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
      chk("b2b_nvalid", {31'd0, bus.valid}, 32'd0);
      step(); neg();
      chk("b2b_rn_b", {29'd0, bus.readnum}, 32'd0);
      chk("b2b_busy_b", {31'd0, bus.busy}, 32'd1);
      step(); neg();
      chk("b2b_valid2", {31'd0, bus.valid}, 32'd1);
      step(); neg();

      // write to R4 on the capture edge: old value expected
      step(); req(3'd4, 3'd2);
      step(); bus.start = 1'b0;
      we = 1'b1; wn = 3'd4; wd = 16'h0001;
      step(); we = 1'b0;
      step(); neg();
      chk("wc_valid", {31'd0, bus.valid}, 32'd1);
      chk("wc_A", {16'd0, bus.A}, 32'h0000_00AA);
      step();

      // earlier write now visible
      step(); req(3'd4, 3'd4);
      step(); bus.start = 1'b0;
      step(); neg();
      chk("wv_valid", {31'd0, bus.valid}, 32'd1);
      step();

      // abort in READ_B
      step();
      bus.start = 1'b1; bus.rn_a = 3'd2; bus.rn_b = 3'd5;
      step(); bus.start = 1'b0;
      step(); neg();
      chk("ab_in_rdb", {29'd0, bus.readnum}, 32'd5);
      chk("ab_A_pre", {16'd0, bus.A}, 32'h0000_1234);
      reset = 1'b1;
      step(); reset = 1'b0;
      neg();
      chk("ab_valid", {31'd0, bus.valid}, 32'd0);
      chk("ab_busy", {31'd0, bus.busy}, 32'd0);
      chk("ab_AB", {bus.A, bus.B}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(); neg();
         chk("ab_novalid", {31'd0, bus.valid}, 32'd0);
      end

      chk("sb_empty", expq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Sequencer on the read side of the 8×16 register file. It accepts a request naming two source registers and drives `readnum` through the file's single combinational read port, one register per cycle. It captures `data_out` into operand registers `A` and `B`, then presents them to the downstream datapath (shifter/ALU) with a valid/ready handshake. It is the reader counterpart to the file's `data_in`/`writenum`/`write` port.

## Interface
- `n`, 16: data width; must match the register file width.
- `k`, 3: register-number width (2^k registers).

- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high; one clock; sampled on `clk` rising edge.
- `start`  input  1  request strobe; accepted only in IDLE, or in HOLD together with `ready`.
- `rn_a`  input  k  source register for `A`; sampled on the accepting edge only.
- `rn_b`  input  k  source register for `B`; sampled on the accepting edge only.
- `readnum`  output  k  to register file read select.
- `data_out`  input  n  from the register file; combinational function of `readnum`.
- `A`  output  n  operand A register.
- `B`  output  n  operand B register.
- `valid`  output  1  `A`/`B` hold a completed fetch.
- `ready`  input  1  consumer accepts `A`/`B` on an edge where `valid`=1.
- `busy`  output  1  high in READ_A and READ_B.

## Operation
- Internal latches `ra_q`, `rb_q` (k bits each) capture `rn_a`/`rn_b` on an accepting edge.
- States: IDLE, READ_A, READ_B, HOLD (one-hot or binary; not externally visible).
- IDLE:
  - `readnum`=0, `valid`=0, `busy`=0.
  - `start`=1 → latch `ra_q`/`rb_q`, go to READ_A.
- READ_A:
  - `readnum`=`ra_q`, `busy`=1.
  - Next edge: `A`<=`data_out`.
  - If `ra_q`==`rb_q`: also `B`<=`data_out` and go to HOLD (same-register shortcut).
  - Otherwise go to READ_B.
- READ_B:
  - `readnum`=`rb_q`, `busy`=1.
  - Next edge: `B`<=`data_out`, go to HOLD.
- HOLD:
  - `readnum`=0, `valid`=1.
  - `ready`=0 → stay in HOLD; `A`/`B` must not change.
  - `ready`=1 and `start`=0 → go to IDLE.
  - `ready`=1 and `start`=1 → latch new `rn_a`/`rn_b`, go directly to READ_A (back-to-back).
- `start` is ignored in READ_A/READ_B, and in HOLD when `ready`=0. Nothing is queued.
- `A`/`B` change only on capture edges. Between fetches they retain their last values; they are not cleared on handshake.
- No arithmetic is performed. Data passes unmodified, full n bits, no sign handling.

## Timing
- Reset values: state=IDLE; `A`=0, `B`=0, `ra_q`=0, `rb_q`=0; `valid`=0, `busy`=0, `readnum`=0.
- `readnum`, `valid` and `busy` are decoded from state and latches only. They are glitch-free per cycle and have no combinational path from `start` or `ready`.
- Latency, accepting edge to first cycle with `valid`=1:
  - 2 edges for distinct registers (READ_A, READ_B).
  - 1 edge when `rn_a`==`rn_b`.
- Throughput with `ready` held at 1 and `start` held at 1:
  - one fetch per 3 cycles for distinct registers, 2 cycles for the same register.
- Write coincidence: if the register file writes register r on the same edge that captures r, the old value is captured. A write on an earlier edge is visible.
- Reset mid-operation (any state) returns to IDLE on that edge. The fetch is abandoned, no `valid` pulse is produced, and `A`/`B` clear to 0.
- `reset` takes priority over `start` and `ready` on the same edge.

## Test plan
- Reset sequence: assert `reset` for 1 cycle with `start`=1 → `valid`=0, `busy`=0, `readnum`=0, `A`=`B`=0 after the edge; no fetch starts.
- Distinct fetch:
  - Setup: file R2=16'h1234, R5=16'hABCD; `start` with `rn_a`=2, `rn_b`=5, `ready`=1.
  - Required: `readnum` sequence is 2, 5; `valid`=1 two edges after accept with `A`=16'h1234, `B`=16'hABCD; IDLE next cycle.
- Same-register shortcut: `rn_a`=`rn_b`=7, R7=16'hFFFF → `readnum`=7 for one cycle only; `valid` one edge after accept; `A`=`B`=16'hFFFF.
- Backpressure:
  - Hold `ready`=0 for 4 cycles in HOLD; pulse `start` with `rn_a`=1 during that time → `valid` stays 1, `A`/`B` unchanged, the `start` is ignored.
  - Then `ready`=1 → IDLE.
- Back-to-back: in HOLD assert `ready`=1 and `start`=1 with `rn_a`=3, `rn_b`=0 → the next cycle is READ_A with `readnum`=3; the second result is valid after 2 more edges.
- Write coincidence and abort:
  - Write R4=16'h0001 on the edge that captures R4 (old value 16'h00AA) → `A`=16'h00AA.
  - Separately, assert `reset` in READ_B → no `valid`; `A`=`B`=0.
